// File: rtl/red_pitaya_pfd_ext_block.sv
// ---------------------------------------------------------------------------
// red_pitaya_pfd_ext_block
//
// Phase-frequency detector for two asynchronous digital inputs. Each input is
// synchronised and edge-detected (rising, falling or both). A signed
// integrator accumulates (edges of s1) - (edges of s2), either saturating at
// the rails or wrapping around. A gated counter alongside it reports per-window
// edge counts of both channels for frequency readout.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset (overrides clear_i)
//   s1_i, s2_i   asynchronous input signals
//   edge_sel_i   00 rising, 01 falling, 10 both, 11 rising
//   wrap_i       1 = wrap-around integrator, 0 = saturating integrator
//   clear_i      clears integrator and discards the current gate window
//   gate_len_i   gate window length in cycles, 0 disables counting
//   integral_o   integrator bits [OW+ISR-1:ISR], two's complement
//   sat_o        saturate: level at a rail; wrap: one-cycle pulse per wrap
//   cnt1_o/cnt2_o  edge counts of the last completed window
//   cnt_valid_o  one-cycle pulse when cnt1_o/cnt2_o update
// ---------------------------------------------------------------------------
module red_pitaya_pfd_ext_block #(
    parameter int OW          = 14,
    parameter int ISR         = 0,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             s1_i,
    input  logic             s2_i,
    input  logic [1:0]       edge_sel_i,
    input  logic             wrap_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] gate_len_i,
    output logic [OW-1:0]    integral_o,
    output logic             sat_o,
    output logic [CNT_W-1:0] cnt1_o,
    output logic [CNT_W-1:0] cnt2_o,
    output logic             cnt_valid_o
);

    localparam int W = OW + ISR;
    localparam logic [W-1:0]     ACC_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]     ACC_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]     ACC_ONE = W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync1, sync2;
    logic                   hist1, hist2;
    logic [1:0]             sel;
    logic                   wrap;
    logic                   e1, e2;

    logic [W-1:0]     acc, acc_next;
    logic             wrapped, sat_next;

    logic [CNT_W-1:0] timer, c1, c2, c1_inc, c2_inc;

    function automatic logic edge_det(input logic cur, input logic prev,
                                      input logic [1:0] mode);
        case (mode)
            2'b01:   return ~cur & prev;
            2'b10:   return cur ^ prev;
            default: return cur & ~prev;
        endcase
    endfunction

    // Mode inputs are registered so a change applies from the next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1 <= '0;
            sync2 <= '0;
            hist1 <= 1'b0;
            hist2 <= 1'b0;
            sel   <= '0;
            wrap  <= 1'b0;
        end else begin
            sync1[0] <= s1_i;
            sync2[0] <= s2_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync1[i] <= sync1[i-1];
                sync2[i] <= sync2[i-1];
            end
            hist1 <= sync1[SYNC_STAGES-1];
            hist2 <= sync2[SYNC_STAGES-1];
            sel   <= edge_sel_i;
            wrap  <= wrap_i;
        end
    end

    assign e1 = edge_det(sync1[SYNC_STAGES-1], hist1, sel);
    assign e2 = edge_det(sync2[SYNC_STAGES-1], hist2, sel);

    always_comb begin
        acc_next = acc;
        wrapped  = 1'b0;
        if (e1 && !e2) begin
            if (acc == ACC_MAX) begin
                if (wrap) begin
                    acc_next = ACC_MIN;
                    wrapped  = 1'b1;
                end
            end else begin
                acc_next = acc + ACC_ONE;
            end
        end else if (e2 && !e1) begin
            if (acc == ACC_MIN) begin
                if (wrap) begin
                    acc_next = ACC_MAX;
                    wrapped  = 1'b1;
                end
            end else begin
                acc_next = acc - ACC_ONE;
            end
        end
        // Saturate mode reports a level aligned with the stored value.
        sat_next = wrap ? wrapped : ((acc_next == ACC_MAX) || (acc_next == ACC_MIN));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            acc   <= '0;
            sat_o <= 1'b0;
        end else begin
            acc   <= acc_next;
            sat_o <= sat_next;
        end
    end

    assign integral_o = acc[W-1:ISR];

    assign c1_inc = (e1 && (c1 != '1)) ? c1 + CNT_ONE : c1;
    assign c2_inc = (e2 && (c2 != '1)) ? c2 + CNT_ONE : c2;

    // The close test uses >= so lowering the length mid-window closes it at once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer       <= '0;
            c1          <= '0;
            c2          <= '0;
            cnt1_o      <= '0;
            cnt2_o      <= '0;
            cnt_valid_o <= 1'b0;
        end else if (clear_i || (gate_len_i == '0)) begin
            timer       <= '0;
            c1          <= '0;
            c2          <= '0;
            cnt_valid_o <= 1'b0;
        end else if (timer >= gate_len_i - CNT_ONE) begin
            timer       <= '0;
            c1          <= '0;
            c2          <= '0;
            cnt1_o      <= c1_inc;
            cnt2_o      <= c2_inc;
            cnt_valid_o <= 1'b1;
        end else begin
            timer       <= timer + CNT_ONE;
            c1          <= c1_inc;
            c2          <= c2_inc;
            cnt_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_red_pitaya_pfd_ext_block.sv
// ---------------------------------------------------------------------------
// tb_red_pitaya_pfd_ext_block
//
// Directed bench for red_pitaya_pfd_ext_block. A default instance (OW=14,
// ISR=0) and an ISR=4 instance share all inputs. Edge-select decoding is
// driven from a vector table; latency, saturation, wrap, gating and clear
// behaviour are covered by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_red_pitaya_pfd_ext_block;

    logic        clk = 1'b0;
    logic        rst, s1, s2, wrap, clear;
    logic [1:0]  sel;
    logic [31:0] gate_len;

    logic [13:0] integral;
    logic        sat, valid;
    logic [31:0] cnt1, cnt2;

    logic [13:0] integral_isr;
    logic        sat_isr, valid_isr;
    logic [31:0] cnt1_isr, cnt2_isr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    red_pitaya_pfd_ext_block #(.OW(14), .ISR(0), .SYNC_STAGES(2), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .s1_i(s1), .s2_i(s2), .edge_sel_i(sel),
        .wrap_i(wrap), .clear_i(clear), .gate_len_i(gate_len),
        .integral_o(integral), .sat_o(sat), .cnt1_o(cnt1), .cnt2_o(cnt2),
        .cnt_valid_o(valid)
    );

    red_pitaya_pfd_ext_block #(.OW(14), .ISR(4), .SYNC_STAGES(2), .CNT_W(32)) dut_isr (
        .clk_i(clk), .rst_i(rst), .s1_i(s1), .s2_i(s2), .edge_sel_i(sel),
        .wrap_i(wrap), .clear_i(clear), .gate_len_i(gate_len),
        .integral_o(integral_isr), .sat_o(sat_isr), .cnt1_o(cnt1_isr), .cnt2_o(cnt2_isr),
        .cnt_valid_o(valid_isr)
    );

    typedef struct {
        logic [1:0] sel;
        logic       s1;
        logic       s2;
        int         exp;
        int         exp_isr;
    } vec_t;

    vec_t tbl[12];

    // Wave/pulse capture state
    int     ph = 0;
    int     np;
    int     pcyc[4];
    longint pc1[4];
    longint pc2[4];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic toggle1(input int n);
        repeat (n) begin
            s1 = ~s1;
            tick();
        end
    endtask

    task automatic toggle2(input int n);
        repeat (n) begin
            s2 = ~s2;
            tick();
        end
    endtask

    task automatic run_count(input int n, output int sat_n, output int valid_n);
        sat_n   = 0;
        valid_n = 0;
        repeat (n) begin
            tick();
            if (sat)   sat_n++;
            if (valid) valid_n++;
        end
    endtask

    // Square wave on s1 with period 10 cycles, capturing the first four pulses.
    task automatic run_wave(input int n);
        np = 0;
        for (int k = 0; k < n; k++) begin
            s1 = ((ph / 5) % 2) == 1;
            ph++;
            tick();
            if (valid) begin
                if (np < 4) begin
                    pcyc[np] = k;
                    pc1[np]  = cnt1;
                    pc2[np]  = cnt2;
                end
                np++;
            end
        end
    endtask

    initial begin
        int sc, vc, w, first;

        tbl[0]  = '{2'b00, 1'b1, 1'b0, 17, 1};
        tbl[1]  = '{2'b00, 1'b0, 1'b0, 17, 1};
        tbl[2]  = '{2'b01, 1'b1, 1'b0, 17, 1};
        tbl[3]  = '{2'b01, 1'b0, 1'b0, 18, 1};
        tbl[4]  = '{2'b10, 1'b1, 1'b0, 19, 1};
        tbl[5]  = '{2'b10, 1'b0, 1'b0, 20, 1};
        tbl[6]  = '{2'b11, 1'b1, 1'b0, 21, 1};
        tbl[7]  = '{2'b11, 1'b0, 1'b0, 21, 1};
        tbl[8]  = '{2'b00, 1'b0, 1'b1, 20, 1};
        tbl[9]  = '{2'b00, 1'b1, 1'b0, 21, 1};
        tbl[10] = '{2'b10, 1'b0, 1'b1, 21, 1};
        tbl[11] = '{2'b01, 1'b0, 1'b0, 20, 1};

        rst = 1'b1; s1 = 1'b0; s2 = 1'b0; wrap = 1'b0; clear = 1'b0;
        sel = 2'b00; gate_len = 32'd0;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_integral", $signed(integral), 0);
            check("rst_sat", sat, 0);
            check("rst_valid", valid, 0);
            check("rst_cnt1", cnt1, 0);
            check("rst_cnt2", cnt2, 0);
            check("rst_integral_isr", $signed(integral_isr), 0);
        end
        rst = 1'b0;
        idle(2);

        // Latency: sampled at edge N, visible after edge N+2
        s1 = 1'b1;
        tick();
        check("lat_n", $signed(integral), 0);
        tick();
        check("lat_n1", $signed(integral), 0);
        tick();
        check("lat_n2", $signed(integral), 1);
        s1 = 1'b0;
        idle(3);

        // ISR=4 truncation
        repeat (14) begin
            s1 = 1'b1; tick();
            s1 = 1'b0; tick();
        end
        idle(4);
        check("isr15_main", $signed(integral), 15);
        check("isr15_isr", $signed(integral_isr), 0);
        s1 = 1'b1; tick();
        s1 = 1'b0; tick();
        idle(4);
        check("isr16_main", $signed(integral), 16);
        check("isr16_isr", $signed(integral_isr), 1);

        // Edge-select decode table
        for (int i = 0; i < 12; i++) begin
            sel = tbl[i].sel;
            s1  = tbl[i].s1;
            s2  = tbl[i].s2;
            idle(4);
            check($sformatf("table[%0d]", i), $signed(integral), tbl[i].exp);
            check($sformatf("table_isr[%0d]", i), $signed(integral_isr), tbl[i].exp_isr);
        end

        // Saturating integrator, both-edge mode for speed
        sel = 2'b10;
        idle(2);
        toggle1(9000);
        idle(4);
        check("sat_pos_val", $signed(integral), 8191);
        check("sat_pos_flag", sat, 1);
        toggle2(1);
        idle(4);
        check("sat_pos_back_val", $signed(integral), 8190);
        check("sat_pos_back_flag", sat, 0);
        toggle2(20000);
        idle(4);
        check("sat_neg_val", $signed(integral), -8192);
        check("sat_neg_flag", sat, 1);

        // Wrap-around integrator
        wrap = 1'b1;
        idle(2);
        s2 = ~s2;
        run_count(6, sc, vc);
        check("wrap_neg_val", $signed(integral), 8191);
        check("wrap_neg_pulse", sc, 1);
        s1 = ~s1;
        run_count(6, sc, vc);
        check("wrap_pos_val", $signed(integral), -8192);
        check("wrap_pos_pulse", sc, 1);
        s1 = ~s1;
        s2 = ~s2;
        run_count(6, sc, vc);
        check("wrap_both_val", $signed(integral), -8192);
        check("wrap_both_pulse", sc, 0);

        // Gate counter, both edges, period-10 wave, 100-cycle window
        s2 = 1'b0;
        sel = 2'b10;
        gate_len = 32'd100;
        run_wave(350);
        check("gate_both_npulses", (np >= 3) ? 1 : 0, 1);
        check("gate_both_period1", pcyc[1] - pcyc[0], 100);
        check("gate_both_period2", pcyc[2] - pcyc[1], 100);
        check("gate_both_cnt1_a", pc1[1], 20);
        check("gate_both_cnt1_b", pc1[2], 20);
        check("gate_both_cnt2", pc2[1], 0);

        // Falling edges only
        sel = 2'b01;
        run_wave(350);
        check("gate_fall_npulses", (np >= 3) ? 1 : 0, 1);
        check("gate_fall_cnt1_a", pc1[1], 10);
        check("gate_fall_cnt1_b", pc1[2], 10);

        // Gating disabled: no pulses, outputs hold
        gate_len = 32'd0;
        run_wave(300);
        check("gate_off_npulses", np, 0);
        check("gate_off_cnt1_hold", cnt1, 10);

        // Reset together with clear
        s1 = 1'b0; s2 = 1'b0; wrap = 1'b0;
        rst = 1'b1; clear = 1'b1;
        tick();
        rst = 1'b0; clear = 1'b0;
        check("rstclr_integral", $signed(integral), 0);
        check("rstclr_cnt1", cnt1, 0);
        check("rstclr_cnt2", cnt2, 0);
        check("rstclr_valid", valid, 0);
        check("rstclr_sat", sat, 0);

        // clear_i mid-window at integral 500
        sel = 2'b10;
        gate_len = 32'd100;
        idle(3);
        check("clr_start", $signed(integral), 0);
        toggle1(500);
        idle(4);
        check("clr_pre_val", $signed(integral), 500);
        w = 0;
        while (!valid && w < 300) begin
            tick();
            w++;
        end
        check("clr_prewindow_seen", valid, 1);
        idle(30);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_integral", $signed(integral), 0);
        check("clr_sat", sat, 0);
        check("clr_valid", valid, 0);
        first = 0;
        for (int k = 1; k <= 150; k++) begin
            tick();
            if (valid && first == 0) first = k;
        end
        check("clr_next_valid_cycle", first, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/red_pitaya_pfd_ext_block.md
Name: red_pitaya_pfd_ext_block

Overview:
Parametrised phase-frequency detector for two digital (comparator/trigger) inputs. Each input passes through a configurable synchroniser and selectable edge detector. A signed integrator accumulates (edges of s1) minus (edges of s2) and supports saturate or wrap-around modes. A gated edge counter runs alongside and reports per-window edge counts of both channels for frequency readout over the register bus.

Parameters:
OW, 14, integrator output width in bits (signed)
ISR, 0, extra integrator LSBs discarded at output (gain = 2^-ISR)
SYNC_STAGES, 2, synchroniser flip-flops per input, legal range 1..4
CNT_W, 32, width of gate timer and edge counters

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; one clock; reset is synchronous and active-high
s1_i  in  1  signal 1 (asynchronous)
s2_i  in  1  signal 2 (asynchronous)
edge_sel_i  in  2  00 rising, 01 falling, 10 both, 11 rising
wrap_i  in  1  1 = wrap-around integrator, 0 = saturating integrator
clear_i  in  1  synchronous clear of integrator and gate window
gate_len_i  in  CNT_W  gate window length in cycles; 0 disables counting
integral_o  out  OW  integrator bits [OW+ISR-1:ISR], two's complement
sat_o  out  1  saturate mode: level, high while integrator sits at a rail; wrap mode: one-cycle pulse per wrap
cnt1_o  out  CNT_W  s1 edge count of last completed window
cnt2_o  out  CNT_W  s2 edge count of last completed window
cnt_valid_o  out  1  one-cycle pulse when cnt1_o/cnt2_o update

Behaviour:
- Reset (rst_i=1 at a clk_i edge): synchronisers, edge history, integrator, gate timer, edge counters, cnt1_o, cnt2_o, cnt_valid_o and sat_o all go to 0. Reset overrides clear_i.
- Sync: s*_i feeds a SYNC_STAGES flop chain. Edge detect compares the chain output with a 1-cycle history flop. Rising = 10, falling = 01, both = either.
- Latency: if s1_i is sampled high at edge N, the integrator update is visible on integral_o after edge N+SYNC_STAGES.
- Integrator: W = OW+ISR bits, signed. Per cycle step: +1 if e1 & !e2; -1 if e2 & !e1; 0 if both or neither.
- Saturate mode: the result is clamped to [-2^(W-1), 2^(W-1)-1]. A step beyond a rail is ignored. sat_o = 1 while integral equals either rail.
- Wrap mode: two's complement wrap (max+1 -> min, min-1 -> max). sat_o pulses for the single cycle after each wrap.
- Priority: rst_i > clear_i > integrator step.
- clear_i: integral <= 0, sat_o <= 0. Gate timer and both edge counters restart at 0, and the partial window is discarded (no cnt_valid_o). cnt1_o and cnt2_o hold their values.
- wrap_i or edge_sel_i change: takes effect from the next cycle. The integral value is kept. Switching wrap -> saturate does not clamp values already inside range.
- Gate counter, gate_len_i = L > 0:
  - The timer counts 0..L-1. Edge counters add 1 per detected edge and saturate at 2^CNT_W-1.
  - On the cycle with timer >= L-1, the window closes: cnt*_o <= count including that cycle's edge, cnt_valid_o = 1 for the next cycle only, and timer and counters restart at 0.
  - Lowering L mid-window below the current timer value closes the window on the next cycle.
- gate_len_i = 0: timer and counters are held at 0, no cnt_valid_o, and cnt*_o hold.
- Edge counting uses the same edge_sel_i setting and runs independently of integrator saturation.

Test Plan:
- Reset, then s1_i held at 0/1 pattern with SYNC_STAGES=2: first s1 rising edge sampled at edge N -> integral_o = 1 after edge N+2; all outputs were 0 during reset.
- Saturate mode, OW=14, ISR=0: 9000 s1 rising edges, no s2 -> integral_o = 8191, sat_o = 1. One s2 edge -> 8190, sat_o = 0. Repeat on the negative side -> -8192.
- Wrap mode: starting at 8191, one s1 edge -> integral_o = -8192 and sat_o pulses for exactly 1 cycle. Simultaneous s1/s2 edges -> no change.
- edge_sel_i=10 (both), square wave on s1_i with period 10 cycles, gate_len_i=100 -> cnt1_o = 20, cnt_valid_o pulses every 100 cycles. edge_sel_i=01 -> cnt1_o = 10.
- ISR=4: 15 s1 edges -> integral_o = 0. 16th edge -> integral_o = 1.
- clear_i asserted mid-window at integral 500 -> integral_o = 0 next cycle, no cnt_valid_o for the aborted window, and the next valid arrives gate_len_i cycles after clear_i. rst_i asserted together with clear_i -> counts reset to 0 as well.
